dp_ram_fifo_ctrl: RTL and testbench

//  Sequences a 16x4 dual-port EBR RAM (LPM_RAM_DP, registered in/out) as a synchronous FIFO.

---
 rtl/dp_fifo_pkg.sv | 14 +
 rtl/dp_fifo_ptr.sv | 22 ++
 rtl/dp_ram_fifo_ctrl.sv | 120 ++++++++++++
 tb/tb_dp_ram_fifo_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dp_fifo_pkg.sv
// Shared constants and types for the dual-port RAM FIFO controller.
// Sized for one 16x4 EBR RAM instance.
package dp_fifo_pkg;

    localparam int W             = 4;
    localparam int AW            = 4;
    localparam int DEPTH         = 1 << AW;
    localparam int AFULL_DEFAULT = 12;

    // One extra MSB on pointers and count distinguishes full from empty.
    typedef logic [AW:0] ptr_t;
    typedef logic [AW:0] cnt_t;

endpackage

// File: rtl/dp_fifo_ptr.sv
// FIFO pointer register: advances by one when enabled.
// The low bits wrap naturally; the MSB toggles on each wrap.
module dp_fifo_ptr
    import dp_fifo_pkg::*;
#(
    parameter int PTR_AW = AW
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    output logic [PTR_AW:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// Sequences a dual-port registered RAM as a synchronous FIFO, with
// occupancy flags, request-error pulses and read-side parity checking.
module dp_ram_fifo_ctrl
    import dp_fifo_pkg::*;
#(
    parameter int lpm_width        = W,
    parameter int lpm_widthad      = AW,
    parameter int lpm_parity_width = 1,
    parameter int AFULL_LEVEL      = AFULL_DEFAULT
)(
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Push,
    input  logic [lpm_width-1:0]        PushData,
    input  logic                        Pop,
    output logic [lpm_width-1:0]        PopData,
    output logic                        PopValid,
    output logic                        Full,
    output logic                        Empty,
    output logic                        AlmostFull,
    output logic [lpm_widthad:0]        Count,
    output logic                        Overflow,
    output logic                        Underflow,
    output logic                        ParityErr,
    input  logic                        ClearErr,
    output logic [lpm_width-1:0]        Data,
    output logic [lpm_widthad-1:0]      WrAddress,
    output logic                        WrEn,
    output logic [lpm_parity_width-1:0] EDI,
    output logic [lpm_widthad-1:0]      RdAddress,
    output logic                        RdEn,
    input  logic [lpm_width-1:0]        Q,
    input  logic [lpm_parity_width-1:0] EDO
);

    localparam int DEPTH_P = 1 << lpm_widthad;

    logic [lpm_widthad:0] wptr;
    logic [lpm_widthad:0] rptr;
    logic [lpm_widthad:0] count;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 pop_valid;
    logic                 par_err;
    logic                 overflow;
    logic                 underflow;
    logic                 mismatch;

    // Flags come from the registered count, so accept decisions see pre-edge state only.
    assign Full       = (count == (lpm_widthad + 1)'(DEPTH_P));
    assign Empty      = (count == '0);
    assign AlmostFull = (count >= (lpm_widthad + 1)'(AFULL_LEVEL));

    assign push_ok = Push & ~Full;
    assign pop_ok  = Pop & ~Empty;

    assign Data      = PushData;
    assign WrAddress = wptr[lpm_widthad-1:0];
    assign WrEn      = push_ok;
    assign EDI       = {lpm_parity_width{^PushData}};
    assign RdAddress = rptr[lpm_widthad-1:0];
    assign RdEn      = pop_ok;

    assign PopData   = Q;
    assign PopValid  = pop_valid;
    assign Count     = count;
    assign Overflow  = overflow;
    assign Underflow = underflow;
    assign ParityErr = par_err;

    assign mismatch = pop_valid & ((^Q) != EDO[0]);

    dp_fifo_ptr #(.PTR_AW(lpm_widthad)) u_wr_ptr (
        .clk   (Clock),
        .reset (Reset),
        .en    (push_ok),
        .ptr   (wptr)
    );

    dp_fifo_ptr #(.PTR_AW(lpm_widthad)) u_rd_ptr (
        .clk   (Clock),
        .reset (Reset),
        .en    (pop_ok),
        .ptr   (rptr)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (push_ok & ~pop_ok) begin
            count <= count + 1'b1;
        end else if (pop_ok & ~push_ok) begin
            count <= count - 1'b1;
        end
    end

    // A read issued on the same edge as Reset never produces a PopValid strobe.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= pop_ok;
            overflow  <= Push & Full;
            underflow <= Pop & Empty;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            par_err <= 1'b0;
        end else if (mismatch) begin
            par_err <= 1'b1;
        end else if (ClearErr) begin
            par_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Randomized and directed bench for dp_ram_fifo_ctrl against a queue-based
// reference model, with a behavioural registered 16x4 dual-port RAM attached.
module tb_dp_ram_fifo_ctrl;
    import dp_fifo_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Push;
    logic [3:0] PushData;
    logic       Pop;
    logic [3:0] PopData;
    logic       PopValid;
    logic       Full;
    logic       Empty;
    logic       AlmostFull;
    logic [4:0] Count;
    logic       Overflow;
    logic       Underflow;
    logic       ParityErr;
    logic       ClearErr;
    logic [3:0] Data;
    logic [3:0] WrAddress;
    logic       WrEn;
    logic       EDI;
    logic [3:0] RdAddress;
    logic       RdEn;
    logic [3:0] Q;
    logic       EDO;

    always #5 Clock = ~Clock;

    dp_ram_fifo_ctrl dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Push       (Push),
        .PushData   (PushData),
        .Pop        (Pop),
        .PopData    (PopData),
        .PopValid   (PopValid),
        .Full       (Full),
        .Empty      (Empty),
        .AlmostFull (AlmostFull),
        .Count      (Count),
        .Overflow   (Overflow),
        .Underflow  (Underflow),
        .ParityErr  (ParityErr),
        .ClearErr   (ClearErr),
        .Data       (Data),
        .WrAddress  (WrAddress),
        .WrEn       (WrEn),
        .EDI        (EDI),
        .RdAddress  (RdAddress),
        .RdEn       (RdEn),
        .Q          (Q),
        .EDO        (EDO)
    );

    // Registered-in/registered-out RAM; inject flips EDO to fake a corrupted read.
    logic [3:0] mem [DEPTH];
    logic       par_mem [DEPTH];
    logic [3:0] ram_q = 4'h0;
    logic       ram_edo = 1'b0;
    logic       inject;

    always @(posedge Clock) begin
        if (WrEn) begin
            mem[WrAddress]     <= Data;
            par_mem[WrAddress] <= EDI;
        end
        if (RdEn) begin
            ram_q   <= mem[RdAddress];
            ram_edo <= par_mem[RdAddress];
        end
    end

    assign Q   = ram_q;
    assign EDO = ram_edo ^ inject;

    int vectors = 0;
    int errors  = 0;

    int   model_q[$];
    int   wr_total;
    int   rd_total;
    bit   exp_valid;
    int   exp_data;
    bit   exp_perr;
    bit   exp_ovf;
    bit   exp_udf;
    cnt_t exp_count;

    task automatic check_output(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational RAM controls, clock, update model, check state.
    task automatic apply_stimulus(input bit rst, input bit push, input int data,
                                  input bit pop, input bit clr, input bit inj);
        bit full_pre;
        bit empty_pre;
        bit mism;
        Reset    = rst;
        Push     = push;
        PushData = data[3:0];
        Pop      = pop;
        ClearErr = clr;
        inject   = inj;
        #1;
        full_pre  = (model_q.size() == DEPTH);
        empty_pre = (model_q.size() == 0);
        check_output("wr_en",   WrEn,      push && !full_pre);
        check_output("rd_en",   RdEn,      pop && !empty_pre);
        check_output("edi",     EDI,       ^data[3:0]);
        check_output("data",    Data,      data & 15);
        check_output("wr_addr", WrAddress, wr_total % DEPTH);
        check_output("rd_addr", RdAddress, rd_total % DEPTH);
        @(posedge Clock);
        mism = exp_valid && inj;
        if (rst) begin
            model_q.delete();
            wr_total  = 0;
            rd_total  = 0;
            exp_valid = 0;
            exp_perr  = 0;
            exp_ovf   = 0;
            exp_udf   = 0;
        end else begin
            exp_ovf = push && full_pre;
            exp_udf = pop && empty_pre;
            if (mism) exp_perr = 1;
            else if (clr) exp_perr = 0;
            exp_valid = pop && !empty_pre;
            if (exp_valid) begin
                exp_data = model_q.pop_front();
                rd_total++;
            end
            if (push && !full_pre) begin
                model_q.push_back(data & 15);
                wr_total++;
            end
        end
        exp_count = cnt_t'(model_q.size());
        #1;
        check_output("count",      Count,      exp_count);
        check_output("full",       Full,       model_q.size() == DEPTH);
        check_output("empty",      Empty,      model_q.size() == 0);
        check_output("almost_full", AlmostFull, model_q.size() >= 12);
        check_output("pop_valid",  PopValid,   exp_valid);
        if (exp_valid) check_output("pop_data", PopData, exp_data);
        check_output("overflow",   Overflow,   exp_ovf);
        check_output("underflow",  Underflow,  exp_udf);
        check_output("parity_err", ParityErr,  exp_perr);
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        Reset    = 1'b1;
        Push     = 1'b0;
        PushData = 4'h0;
        Pop      = 1'b0;
        ClearErr = 1'b0;
        inject   = 1'b0;
        wr_total = 0;
        rd_total = 0;
        exp_valid = 0;
        exp_data  = 0;
        exp_perr  = 0;
        exp_ovf   = 0;
        exp_udf   = 0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);

        $display("[TB] reset state");
        apply_stimulus(1, 0, 0, 0, 0, 0);

        $display("[TB] fill to full, then drain in order");
        for (int i = 0; i < 16; i++) apply_stimulus(0, 1, i, 0, 0, 0);
        apply_stimulus(0, 1, 9, 0, 0, 0);
        for (int i = 0; i < 16; i++) apply_stimulus(0, 0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] push+pop at full and at empty");
        for (int i = 0; i < 16; i++) apply_stimulus(0, 1, 15 - i, 0, 0, 0);
        apply_stimulus(0, 1, 3, 1, 0, 0);
        for (int i = 0; i < 15; i++) apply_stimulus(0, 0, 0, 1, 0, 0);
        apply_stimulus(0, 1, 7, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0);

        $display("[TB] interleaved streaming across pointer wrap");
        apply_stimulus(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) apply_stimulus(0, 1, $urandom_range(15), 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0);
        idle(1);

        $display("[TB] parity error injection and clearing");
        apply_stimulus(0, 1, 5, 0, 0, 0);
        apply_stimulus(0, 1, 5, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 1);
        idle(2);
        apply_stimulus(0, 0, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 1, 5, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 0, 1, 0);

        $display("[TB] reset with reads in flight");
        for (int i = 0; i < 8; i++) apply_stimulus(0, 1, i + 8, 0, 0, 0);
        apply_stimulus(0, 0, 0, 1, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) apply_stimulus(0, 1, i, 0, 0, 0);
        apply_stimulus(1, 0, 0, 1, 0, 0);
        idle(1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            apply_stimulus($urandom_range(99) == 0,
                           $urandom_range(99) < 55,
                           $urandom_range(15),
                           $urandom_range(99) < 50,
                           $urandom_range(9) == 0,
                           $urandom_range(9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
